// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] onehot_from_index(input logic [$clog2(MAX_REQ)-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Upstream request bundle and downstream stream of the packet arbiter.
interface rr_packet_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_priority_select #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] sel
);

    localparam int PTR_W = $clog2(N_REQ);

    int unsigned idx;

    // Scan from the farthest offset back to ptr so the closest request overwrites last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            idx = 32'(ptr) + k - 1;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// N-way round-robin arbiter that locks the shared output stream to one source per packet.
module rr_packet_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_packet_arbiter_if.slave   bus,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic [PTR_W-1:0] pick, sel;
    logic [N_REQ-1:0] sel_oh;
    logic             found, active, vld, lst, accept;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_priority_select #(.N_REQ(N_REQ)) u_select (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .found (found),
        .sel   (pick)
    );

    // Outputs are gated by rst so nothing is offered while the flops are being cleared.
    always_comb begin
        sel    = (state == ARB_LOCKED) ? owner : pick;
        active = !rst && ((state == ARB_LOCKED) || found);
        sel_oh = N_REQ'(onehot_from_index(4'(sel)));
        vld    = active && bus.req_valid[sel];
        lst    = active && bus.req_last[sel];
        accept = vld && bus.out_ready;

        grant         = active ? sel_oh : '0;
        bus.req_ready = (active && bus.out_ready) ? sel_oh : '0;
        bus.out_valid = vld;
        bus.out_last  = lst;
        bus.out_data  = bus.req_data[sel*DATA_W +: DATA_W];
        busy          = !rst && (state == ARB_LOCKED);
    end

    // A stalled first beat also locks, so the offered beat cannot switch source.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        case (state)
            ARB_IDLE: begin
                if (vld) begin
                    if (accept && lst) begin
                        ptr_nxt = wrap_inc(sel);
                    end else begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = sel;
                    end
                end
            end
            ARB_LOCKED: begin
                if (accept && lst) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = wrap_inc(owner);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed and randomized checks of rr_packet_arbiter against a behavioural arbitration model.
module tb_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] grant;
    logic         busy;

    logic [N-1:0]    rv = '0;
    logic [N-1:0]    rl = '0;
    logic [N*DW-1:0] rd = '0;
    logic            ready = 1'b0;

    rr_packet_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    assign bus.req_valid = rv;
    assign bus.req_last  = rl;
    assign bus.req_data  = rd;
    assign bus.out_ready = ready;

    rr_packet_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: -1 means no packet owns the output.
    int m_lock = -1;
    int m_ptr  = 0;

    logic [N-1:0] acc;
    logic         sb_on = 1'b0;
    int           cur_pkt = -1;
    logic [5:0]   exp_seq [N];
    logic [5:0]   seq [N];
    int           rem [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model at negedge, then advance both.
    task automatic step(input int exp_grant);
        int         s;
        int         src;
        logic [N-1:0] eg, er;
        logic       ev, el, acc_m;
        @(negedge clk);
        s = -1;
        if (!rst) begin
            if (m_lock >= 0) s = m_lock;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (s < 0 && rv[(m_ptr + k) % N]) s = (m_ptr + k) % N;
                end
            end
        end
        eg = (s >= 0) ? N'(1 << s) : '0;
        ev = (s >= 0) ? rv[s] : 1'b0;
        el = (s >= 0) ? rl[s] : 1'b0;
        er = ready ? eg : '0;

        check("grant", 32'(grant), 32'(eg));
        check("req_ready", 32'(bus.req_ready), 32'(er));
        check("out_valid", 32'(bus.out_valid), 32'(ev));
        check("out_last", 32'(bus.out_last), 32'(el));
        check("busy", 32'(busy), 32'(!rst && m_lock >= 0));
        if (ev) check("out_data", 32'(bus.out_data), 32'(rd[s*DW +: DW]));
        if (!rst) check("ptr", 32'(dut.ptr), 32'(m_ptr));
        if (exp_grant >= 0) check("grant_seq", 32'(grant), 32'(exp_grant));

        acc = bus.req_valid & bus.req_ready;
        if (sb_on && bus.out_valid && bus.out_ready) begin
            src = int'(bus.out_data[7:6]);
            if (cur_pkt >= 0) check("no_interleave", 32'(src), 32'(cur_pkt));
            check("beat_order", 32'(bus.out_data[5:0]), 32'(exp_seq[src]));
            exp_seq[src] = exp_seq[src] + 1'b1;
            cur_pkt = bus.out_last ? -1 : src;
        end

        acc_m = ev && ready;
        if (rst) begin
            m_lock  = -1;
            m_ptr   = 0;
            cur_pkt = -1;
        end else if (s >= 0) begin
            if (m_lock >= 0) begin
                if (acc_m && el) begin
                    m_ptr  = (m_lock + 1) % N;
                    m_lock = -1;
                end
            end else if (acc_m && el) begin
                m_ptr = (s + 1) % N;
            end else begin
                m_lock = s;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd = 32'h44332211;

        rst = 1'b1;
        step(0);
        step(0);
        rst = 1'b0;

        // Single-beat round robin with everyone valid.
        rv = 4'b1111; rl = 4'b1111; ready = 1'b1;
        for (int c = 0; c < 8; c++) step(1 << (c % 4));

        // Req 0 sends 3 beats while req 2 waits.
        for (int b = 0; b < 3; b++) begin
            rv = 4'b0101;
            rl = (b == 2) ? 4'b0101 : 4'b0100;
            rd[7:0] = 8'h10 + 8'(b);
            step(4'b0001);
        end
        rv = 4'b0100; rl = 4'b0100;
        step(4'b0100);

        // Backpressure on req 1 (ptr wraps 3 -> 0 -> 1), req 3 arrives mid-stall.
        ready = 1'b0; rl = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            rv = (c >= 2) ? 4'b1010 : 4'b0010;
            step(4'b0010);
        end
        ready = 1'b1;
        step(4'b0010);
        rv = 4'b1000;
        step(4'b1000);

        // Wrap and skip: get ptr to 3, then only req 1 is valid.
        rv = 4'b0100; rl = 4'b0100;
        step(4'b0100);
        rv = 4'b0010; rl = 4'b0010;
        step(4'b0010);

        // Reset in the middle of a 4-beat packet from req 2.
        rv = 4'b0100; rl = 4'b0000;
        step(4'b0100);
        step(4'b0100);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        rv = 4'b0101; rl = 4'b0101;
        step(4'b0001);
        step(4'b0100);

        // Idle.
        rv = '0; rl = '0;
        for (int c = 0; c < 10; c++) step(0);

        // Randomized traffic from well-behaved packet sources.
        for (int i = 0; i < N; i++) begin
            seq[i] = '0; exp_seq[i] = '0; rem[i] = 0;
            rd[i*DW +: DW] = {2'(i), 6'd0};
        end
        rv = '0; rl = '0;
        cur_pkt = -1;
        sb_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            ready = ($urandom_range(0, 9) < 7);
            step(-1);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    seq[i] = seq[i] + 1'b1;
                    rem[i] = rem[i] - 1;
                end
                if (rst) begin
                    rem[i] = 0;
                    rv[i]  = 1'b0;
                end else if (!(rv[i] && !acc[i])) begin
                    if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
                    rv[i] = (rem[i] != 0) && ($urandom_range(0, 3) != 0);
                end
                rl[i] = (rem[i] == 1);
                rd[i*DW +: DW] = {2'(i), seq[i]};
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
